// File: rtl/dcache_pkg.sv
// Shared types, widths and address-slicing helpers for the L1 data cache.
package dcache_pkg;

    localparam int OFFSET_W = 5;
    localparam int BLOCK_W  = 256;
    localparam int WORD_W   = 32;
    localparam int WSEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    // Helpers take a zero-extended address; callers cast the result to their field width.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
        return addr >> (OFFSET_W + idx_w);
    endfunction

    function automatic logic [63:0] addr_idx(input logic [63:0] addr, input int idx_w);
        return (addr >> OFFSET_W) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [WSEL_W-1:0] addr_wsel(input logic [63:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: asynchronous read, synchronous block-fill and word-write ports.
// Valid and dirty bits reset; tag and data contents are left as they are.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 23,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] data_o,
    input  logic               fill_en_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [BLOCK_W-1:0] fill_data_i,
    input  logic               word_we_i,
    input  logic [WSEL_W-1:0]  word_sel_i,
    input  logic [WORD_W-1:0]  word_data_i
);

    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];
    logic [BLOCK_W-1:0] data_d [LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    // Next array contents: a fill installs a clean line, a word write marks it dirty.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
            tag_d[idx_i]   = fill_tag_i;
            data_d[idx_i]  = fill_data_i;
        end else if (word_we_i) begin
            dirty_d[idx_i] = 1'b1;
            data_d[idx_i][{word_sel_i, 5'b0} +: WORD_W] = word_data_i;
        end
    end

    // Line state bits, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage, never reset.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller for the MEM stage.
// Hits finish in the request cycle; misses stall while a dirty victim is written back
// and the block is fetched, then the access replays as a hit.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADDR_W-1:0]  cpu_addr_i,
    input  logic [WORD_W-1:0]  cpu_data_i,
    input  logic               cpu_MemRead_i,
    input  logic               cpu_MemWrite_i,
    output logic [WORD_W-1:0]  cpu_data_o,
    output logic               cpu_stall_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  req_wsel;
    logic               request, hit;
    logic               line_valid, line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               fill_en, word_we, hit_idle, miss_start;

    assign req_idx  = IDX_W'(addr_idx(64'(cpu_addr_i), IDX_W));
    assign req_tag  = TAG_W'(addr_tag(64'(cpu_addr_i), IDX_W));
    assign req_wsel = addr_wsel(64'(cpu_addr_i));
    assign request  = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit      = request & line_valid & (line_tag == req_tag);

    // Gated by reset so the stall is low while reset is held.
    assign cpu_stall_o = rst_i & request & ~hit;
    // A store wins over a load, so a combined request returns nothing.
    assign cpu_data_o  = (hit & cpu_MemRead_i & ~cpu_MemWrite_i)
                         ? line_data[{req_wsel, 5'b0} +: WORD_W] : '0;

    dcache_sram #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .fill_en_i   (fill_en),
        .fill_tag_i  (req_tag),
        .fill_data_i (mem_data_i),
        .word_we_i   (word_we),
        .word_sel_i  (req_wsel),
        .word_data_i (cpu_data_i)
    );

    // Miss FSM: next state, array write strobes and memory request.
    always_comb begin
        state_d      = state_q;
        fill_en      = 1'b0;
        word_we      = 1'b0;
        hit_idle     = 1'b0;
        miss_start   = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        hit_idle = 1'b1;
                        word_we  = cpu_MemWrite_i;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = (line_valid & line_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag, req_idx, {OFFSET_W{1'b0}}};
                mem_data_o   = line_data;
                if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any miss in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        replay_q, replay_d;

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    // Count misses at their start and hits except the replay right after a fill.
    always_comb begin
        replay_d   = fill_en;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_idle && !replay_q) hit_cnt_d  = hit_cnt_q + 32'd1;
        if (miss_start)            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    // Counter registers, wrapping naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            replay_q   <= replay_d;
        end
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage of the 5-stage pipeline; it sits directly upstream of the MEM/WB pipeline register and supplies its load data. Hits complete in the request cycle with no stall. Misses stall the pipeline while the controller writes back a dirty victim, fetches the 256-bit block from off-chip data memory, and then replays the access as a hit.

## Interface
- LINES, 16, number of cache lines; power of two, ≥2; IDX_W = log2(LINES).
- ADDR_W, 32, byte-address width; TAG_W = ADDR_W − IDX_W − 5.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- cpu_addr_i  in  ADDR_W  byte address; [4:2] word select, [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request; wins if both are high.
- cpu_data_o  out  32  load data: selected word on a read hit, else 0.
- cpu_stall_o  out  1  freeze the pipeline, including the MEM/WB register's inputs.
- mem_addr_o  out  ADDR_W  block address to memory; [4:0] = 0.
- mem_data_o  out  256  write-back block.
- mem_enable_o  out  1  memory request; level, held until ack.
- mem_write_o  out  1  1 = write-back, 0 = fill.
- mem_data_i  in  256  fill block; valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.

## Operation
- Request = cpu_MemRead_i | cpu_MemWrite_i. Hit = request & valid[idx] & (tag[idx] == addr tag), where idx = addr[IDX_W+4:5].
- cpu_stall_o = request & ~hit. It is combinational and asserts in the first miss cycle.
- Upstream holds every cpu_* input stable while cpu_stall_o is high.
- Store hit: at the edge, write cpu_data_i into word addr[4:2] and set dirty[idx].
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE → WRITEBACK: request misses and the victim is valid and dirty.
- IDLE → ALLOCATE: request misses and the victim is clean or invalid.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, idx, 5'b0}, mem_data_o = victim block. On mem_ack_i go to ALLOCATE.
- ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, idx, 5'b0}. On mem_ack_i load mem_data_i into the line, set valid=1, dirty=0, tag=req tag, and go to IDLE.
- Replay: the next cycle is a hit. A store replay then sets dirty.
- Outside WRITEBACK and ALLOCATE, mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are all 0.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- No request in IDLE: no state change.

## Timing
- Reset (rst_i low, asynchronous): state=IDLE; all valid and dirty bits = 0; every output = 0. Data and tag arrays are not cleared.
- Reset mid-miss: the transaction is abandoned and mem_enable_o drops immediately. Dirty data is lost by design.
- Hit latency: 0 cycles; cpu_data_o is valid in the request cycle.
- Clean miss with ack N cycles after the request is raised: stall for N+1 cycles.
- Dirty miss: stall = write-back ack latency + fill ack latency + 1.
- mem_ack_i in the first cycle of a state is legal and advances the state at that edge.
- Back-to-back misses to the same index behave correctly: the second miss evicts the line just filled.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0 and wrapping modulo 2^32.
  - miss_cnt_o increments once per IDLE→WRITEBACK/ALLOCATE transition.
  - hit_cnt_o increments on each IDLE hit except the replay cycle following ALLOCATE.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, ALLOCATE);
  - OFFSET_W=5, BLOCK_W=256, WORD_W=32;
  - address-field slicing helper functions (tag, index, word select).
- Sub-module dcache_sram: tag, valid, dirty and data arrays.
  - Asynchronous read; synchronous write with full-block and single-word write ports.
- dcache_ctrl holds the FSM, hit logic, memory interface and stats.

## Test plan
- Reset, then load 0x0000_0040 → miss; ALLOCATE at 0x40; ack with pattern P; stall drops next cycle; cpu_data_o = P word 0.
- Store 0xDEAD_BEEF to 0x44 after the fill → no stall; load 0x44 returns 0xDEAD_BEEF; dirty[2]=1.
- With LINES=16, load 0x0000_0240 (same index, new tag) → WRITEBACK at 0x40 with the modified block, then ALLOCATE at 0x240; stall = wb latency + fill latency + 1.
- MemRead and MemWrite both high on a hit → a store is performed; cpu_data_o = 0.
- rst_i low during ALLOCATE → mem_enable_o = 0 in the same cycle; after release, the prior address misses again.
- DCACHE_STATS_EN defined, sequence miss, hit, hit, dirty miss → miss_cnt_o = 2, hit_cnt_o = 2 (replays excluded).
